// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped 32-bit down-counting timer/counter
//
// Purpose:
//   Down-counting timer with one-shot and auto-reload modes and a maskable
//   level interrupt.
//   Register map (word address):
//     0 = CTRL   : bit0 enable, bits2:1 mode (01 auto-reload, others one-shot),
//                  bit3 IM interrupt mask
//     1 = PRESET : 32-bit reload value
//     2 = COUNT  : 32-bit current count, read-only
//     3 = reserved
//
// Ports:
//   clk    in   1   system clock, rising-edge active
//   reset  in   1   asynchronous active-low reset
//   addr   in   2   word address (CPU address bits [3:2])
//   we     in   1   write strobe, sampled every cycle
//   din    in  32   write data
//   dout   out 32   read data, combinational from addr
//   irq    out  1   interrupt request, level (irq_flag & IM)

module timer_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CNT  = 2'd1,
      ST_INT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        irq_flag_q, irq_flag_d;

   logic        ctrl_wr;
   logic        preset_wr;
   logic        reload_ok;

   assign ctrl_wr   = we && (addr == 2'd0);
   assign preset_wr = we && (addr == 2'd1);

   // Only mode 01 reloads; reserved modes 10/11 behave as one-shot.
   assign reload_ok = ctrl_q[0] && (ctrl_q[2:1] == 2'b01);

   // State register (and all other storage)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= 4'd0;
         preset_q   <= 32'd0;
         count_q    <= 32'd0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_q[0]) state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_q[0])            state_d = ST_IDLE;
            else if (count_q <= 32'd1) state_d = ST_INT;
         end
         ST_INT: begin
            state_d = reload_ok ? ST_CNT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Register / datapath next values
   always_comb begin
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;

      if (preset_wr) preset_d = din;

      // One-shot completion drops enable; a CPU CTRL write in the same
      // cycle overrides every CTRL bit, so it is applied afterwards.
      if ((state_q == ST_INT) && !reload_ok) ctrl_d[0] = 1'b0;

      if (ctrl_wr) begin
         ctrl_d     = din[3:0];
         irq_flag_d = 1'b0;
      end

      // FSM updates come last so that setting irq_flag beats a
      // same-cycle clear from a CTRL write.
      case (state_q)
         ST_IDLE: begin
            if (ctrl_q[0]) count_d = preset_q;
         end
         ST_CNT: begin
            if (ctrl_q[0]) begin
               if (count_q > 32'd1) begin
                  count_d = count_q - 32'd1;
               end else begin
                  count_d    = 32'd0;
                  irq_flag_d = 1'b1;
               end
            end
         end
         ST_INT: begin
            if (reload_ok) begin
               count_d    = preset_q;
               irq_flag_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      dout = 32'd0;
      case (addr)
         2'd0:    dout = {28'd0, ctrl_q};
         2'd1:    dout = preset_q;
         2'd2:    dout = count_q;
         default: dout = 32'd0;
      endcase
      irq = irq_flag_q & ctrl_q[3];
   end

endmodule
